// File: rtl/mux_scan_ctrl.sv
// Scans the select of an external Nx1 mux through 0..N-1 and assembles the sampled Y bits into one word.
// Optional MUX_SCAN_CONT_EN: after each accepted word, restart the scan directly instead of returning to IDLE.
//
// state | meaning
// IDLE  | waiting for start; sel and data_out keep their last values
// SCAN  | one Y sample per edge into data_out[sel], sel advancing to N-1
// HOLD  | word complete, valid high until the consumer takes it

module mux_scan_ctrl #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [SW-1:0] sel,
  input  logic          y,
  output logic [N-1:0]  data_out,
  output logic          valid,
  input  logic          ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);

  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            sel   <= '0;
            busy  <= 1'b1;
          end
        end

        SCAN: begin
          // Only bit sel is written; the rest keep their previous contents.
          for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) data_out[i] <= y;
          end
          if (sel == SEL_LAST) begin
            state <= HOLD;
            valid <= 1'b1;
          end else begin
            sel <= sel + SW'(1);
          end
        end

        HOLD: begin
          if (valid && ready) begin
            valid <= 1'b0;
`ifdef MUX_SCAN_CONT_EN
            state <= SCAN;
            sel   <= '0;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end

        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized scoreboard bench for mux_scan_ctrl: N=8 main instance plus an N=5 instance for the non-power-of-two case.
// Expectations come from the scan timing rules: start at edge t, bit i sampled at edge t+1+i, valid after edge t+N.

module tb_mux_scan_ctrl;

  localparam int N   = 8;
  localparam int SW  = 3;
  localparam int N5  = 5;
  localparam int SW5 = 3;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic          y;
  logic [SW-1:0] sel;
  logic [N-1:0]  data_out;
  logic          valid;
  logic          busy;
  logic [N-1:0]  d = '0;

  logic           start5 = 1'b0;
  logic           ready5 = 1'b1;
  logic           y5;
  logic [SW5-1:0] sel5;
  logic [N5-1:0]  data5;
  logic           valid5;
  logic           busy5;
  logic [N5-1:0]  d5 = '0;

  assign y  = d[sel];
  assign y5 = (int'(sel5) < N5) ? d5[sel5] : 1'b0;

  mux_scan_ctrl #(.N(N), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .y(y),
    .data_out(data_out), .valid(valid), .ready(ready), .busy(busy)
  );

  mux_scan_ctrl #(.N(N5), .SW(SW5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .sel(sel5), .y(y5),
    .data_out(data5), .valid(valid5), .ready(ready5), .busy(busy5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct { logic [N-1:0]  word; int due; } exp_t;
  typedef struct { logic [N5-1:0] word; int due; } exp5_t;
  exp_t  q[$];
  exp5_t q5[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_sel", sel, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel5", sel5, 0);
    chk("rst_data5", data5, 0);
    chk("rst_valid5", valid5, 0);
    chk("rst_busy5", busy5, 0);
  endtask

  // Scoreboard monitors: a new word is a rising valid; while it is held it must stay put.
  logic pv = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) pv = 1'b0;
    else begin
      if (valid && !pv) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word: got %0h expected no word (cycle %0d)", data_out, cyc);
        end else begin
          cur = q.pop_front();
          chk("word_data", data_out, cur.word);
          chk("word_latency", cyc, cur.due);
          chk("word_sel", sel, N - 1);
          chk("word_busy", busy, 1);
        end
      end else if (valid) begin
        chk("hold_data", data_out, cur.word);
        chk("hold_sel", sel, N - 1);
      end
      pv = valid;
    end
  end

  logic  pv5 = 1'b0;
  exp5_t cur5;
  always @(negedge clk) begin
    if (rst) pv5 = 1'b0;
    else begin
      chk("sel5_range", int'(sel5) <= N5 - 1, 1);
      if (valid5 && !pv5) begin
        if (q5.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word5: got %0h expected no word (cycle %0d)", data5, cyc);
        end else begin
          cur5 = q5.pop_front();
          chk("word5_data", data5, cur5.word);
          chk("word5_latency", cyc, cur5.due);
          chk("word5_sel", sel5, N5 - 1);
        end
      end
      pv5 = valid5;
    end
  end

  // One single-shot word; called at a negedge with the DUT idle.
  task automatic run_word(input bit rnd, input logic [N-1:0] fixed, input int hold,
                          input bit spam, input int abort_at);
    logic [N-1:0] dv [N];
    logic [N-1:0] w;
    int c;
    for (int i = 0; i < N; i++) begin
      dv[i] = rnd ? N'($urandom) : fixed;
      w[i]  = dv[i][i];
    end
    c     = cyc;
    start = 1'b1;
    ready = (hold == 0);
    if (abort_at < 0) q.push_back('{w, c + 1 + N});
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("scan_sel", sel, i);
      chk("scan_busy", busy, 1);
      chk("scan_valid", valid, 0);
      d = dv[i];
      if (spam) start = 1'($urandom_range(0, 1));
      if (i == abort_at) begin
        start = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_values();
        #1 rst = 1'b0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < hold; k++) begin
      chk("wait_valid", valid, 1);
      if (spam) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ready = 1'b1;
    if (spam) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("after_valid", valid, 0);
    chk("after_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid, 0);
    end
  endtask

  task automatic run_word5(input logic [N5-1:0] w);
    int c;
    c      = cyc;
    d5     = w;
    start5 = 1'b1;
    q5.push_back('{w, c + 1 + N5});
    @(negedge clk);
    start5 = 1'b0;
    for (int k = 0; k < N5 + 2; k++) @(negedge clk);
`ifndef MUX_SCAN_CONT_EN
    chk("n5_idle", busy5, 0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_values();
    rst = 1'b0;
    @(negedge clk);

`ifndef MUX_SCAN_CONT_EN
    run_word(1'b0, 8'hA5, 0, 1'b0, -1);
    run_word(1'b0, 8'h3C, 5, 1'b0, -1);
    run_word(1'b1, '0, 2, 1'b1, -1);
    run_word(1'b1, '0, 0, 1'b1, -1);
    run_word(1'b1, '0, 0, 1'b0, 4);
    run_word(1'b1, '0, 1, 1'b0, -1);
    for (int r = 0; r < 6; r++)
      run_word(1'b1, '0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    run_word5(5'b10110);
    run_word5(N5'($urandom));
`else
    begin
      int c;
      ready = 1'b1;
      d     = 8'hFF;
      c     = cyc;
      start = 1'b1;
      q.push_back('{8'hFF, c + 1 + N});
      q.push_back('{8'h00, c + 2 + 2 * N});
      for (int k = 0; k < 2 * N + 2; k++) begin
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        if (cyc == c + 1 + N) d = '0;
        chk("cont_busy", busy, 1);
      end
      start = 1'b0;
      ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1 chk_reset_values();
      #1 rst = 1'b0;
      @(negedge clk);
      ready5 = 1'b0;
      run_word5(5'b10110);
    end
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("queue5_empty", q5.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, meaning the number of mux data inputs scanned (N >= 2).
REQ-002 SHALL have parameter SW, default 3, meaning the select width; SW SHALL equal ceil(log2(N)).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, a request to begin one scan.
REQ-006 SHALL have port sel, output, SW, the registered select driving the downstream Nx1 mux S input.
REQ-007 SHALL have port y, input, 1, the mux output Y, combinationally dependent on sel.
REQ-008 SHALL have port data_out, output, N, the assembled word; bit i is y sampled while sel == i.
REQ-009 SHALL have port valid, output, 1; data_out holds a complete word.
REQ-010 SHALL have port ready, input, 1; the consumer accepts data_out.
REQ-011 SHALL have port busy, output, 1; high in SCAN or HOLD.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN and HOLD.
REQ-013 IDLE: start == 1 at an edge SHALL set sel = 0 and move to SCAN.
REQ-014 SCAN: each edge SHALL write y into data_out[sel], then increment sel if sel < N-1; at sel == N-1 SHALL keep sel, move to HOLD and set valid = 1.
REQ-015 Latency: start sampled at edge t SHALL give valid = 1 after edge t+N; the bit-i sample is taken at edge t+1+i.
REQ-016 Bits of data_out not yet written in the current scan SHALL hold their previous values until overwritten.
REQ-017 HOLD: data_out and sel SHALL be stable; valid && ready at an edge SHALL clear valid and move to IDLE.
REQ-018 start SHALL be ignored in SCAN and HOLD; it is never queued.
REQ-019 start high in the same cycle as the HOLD handshake SHALL be ignored; a new scan needs start in IDLE.
REQ-020 When N is not a power of two, sel SHALL never exceed N-1 (no wrap through unused codes).
REQ-021 busy SHALL be 1 exactly when the state is SCAN or HOLD.

Reset
REQ-022 rst == 1 SHALL immediately force state IDLE, sel = 0, data_out = 0, valid = 0, busy = 0, with no clock edge required.
REQ-023 rst asserted mid-SCAN or mid-HOLD SHALL abort the scan; no partial word is ever flagged valid.

Configuration
REQ-024 Macro MUX_SCAN_CONT_EN SHALL select continuous mode.
REQ-025 With MUX_SCAN_CONT_EN defined, the HOLD handshake SHALL go directly to SCAN with sel = 0, so the next word's bit 0 is sampled at the edge after the handshake; start then only leaves IDLE after reset.
REQ-026 Without MUX_SCAN_CONT_EN, behaviour SHALL be exactly REQ-013 to REQ-019 (single-shot).

Verification
REQ-027 N=8, mux D=8'hA5, pulse start, ready=1 -> sel steps 0..7 on consecutive edges, valid high N edges after start, data_out=8'hA5, valid clears after 1 cycle.
REQ-028 N=8, D=8'h3C, ready=0 for 5 cycles after valid -> data_out=8'h3C, sel=7 and valid=1 held stable; IDLE after ready rises.
REQ-029 start pulsed repeatedly during SCAN and during the HOLD handshake -> exactly one word produced, state IDLE afterwards, busy=0.
REQ-030 rst asserted asynchronously when sel=4 mid-scan -> immediately sel=0, data_out=0, valid=0, busy=0; a later start yields a correct full word.
REQ-031 N=5, SW=3, D=5'b10110 -> sel never exceeds 4, data_out=5'b10110.
REQ-032 MUX_SCAN_CONT_EN defined, ready=1, D changed from 8'hFF to 8'h00 between words -> back-to-back words 8'hFF then 8'h00 with no IDLE cycle between.
